// File: rtl/iterative_divider.sv
`default_nettype none
// ============================================================================
// Module   : iterative_divider
// Brief    : Multi-cycle restoring divider with RISC-V DIV/DIVU/REM/REMU results.
// Revision : 1.0
// ============================================================================
module iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div_mag;
    logic [WIDTH-1:0] r_orig_dividend;
    logic             r_div_zero;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_mag1   = (is_signed && input1[WIDTH-1]) ? (-input1) : input1;
    assign w_mag2   = (is_signed && input2[WIDTH-1]) ? (-input2) : input2;
    // Partial remainder gains the next dividend bit; the extra MSB is the trial sign.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_div_mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_count == c_LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count         <= '0;
            r_rem           <= '0;
            r_quo           <= '0;
            r_div_mag       <= '0;
            r_orig_dividend <= '0;
            r_div_zero      <= 1'b0;
            r_q_neg         <= 1'b0;
            r_r_neg         <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_quotient      <= '0;
            r_remainder     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_orig_dividend <= input1;
                        r_div_zero      <= (input2 == '0);
                        r_q_neg         <= is_signed && (input1[WIDTH-1] ^ input2[WIDTH-1]);
                        r_r_neg         <= is_signed && input1[WIDTH-1];
                        r_quo           <= w_mag1;
                        r_div_mag       <= w_mag2;
                        r_rem           <= '0;
                        r_count         <= '0;
                        r_busy          <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_count <= r_count + c_CNT_ONE;
                end
                S_FIX: begin
                    // Divide by zero bypasses sign correction entirely.
                    if (r_div_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_orig_dividend;
                    end else begin
                        r_quotient  <= r_q_neg ? (-r_quo) : r_quo;
                        r_remainder <= r_r_neg ? (-r_rem) : r_rem;
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_iterative_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_divider
// Brief    : Self-checking bench: directed vector table, handshake/reset cases, random ops.
// Revision : 1.0
// ============================================================================
module tb_iterative_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_fail   = 0;

    iterative_divider #(.WIDTH(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .input1    (input1),
        .input2    (input2),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    // Called at a negedge; leaves at the negedge where done is seen (or on timeout).
    // poke >= 0 pulses start with junk operands at that cycle after acceptance.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int poke, output logic [31:0] q, output logic [31:0] r,
                          output int lat, output int busy_cnt);
        start = 1'b1; input1 = a; input2 = b; is_signed = s;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("done_low_after_accept", {31'd0, done}, 32'd0);
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (lat == poke) begin
                start = 1'b1; input1 = 32'd5; input2 = 32'd3; is_signed = 1'b1;
            end
            if (busy) busy_cnt++;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: no done within %0d cycles", lat);
        end
        q = quotient;
        r = remainder;
    endtask

    initial begin
        logic [31:0] q, r, a, b;
        logic [63:0] exp;
        logic        s;
        int          lat, bc;

        vecs[0] = '{32'd1000,       32'd10,         1'b0, 32'd100,        32'd0};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{32'd1234,       32'd0,          1'b1, 32'hFFFF_FFFF,  32'd1234};
        vecs[4] = '{32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'd1234};
        vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
        vecs[7] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; input1 = '0; input2 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table entries run back-to-back: each start is raised in the previous done cycle.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, -1, q, r, lat, bc);
            check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d_latency", i), lat, 32'd33);
            check($sformatf("vec%0d_busy_cycles", i), bc, 32'd33);
        end

        // done is a single-cycle pulse and results hold while idle
        @(negedge clk);
        check("done_pulse_falls", {31'd0, done}, 32'd0);
        check("hold_quotient", quotient, 32'd14);
        check("hold_remainder", remainder, 32'd2);
        repeat (3) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // start during busy is ignored
        run_op(32'd1000, 32'd10, 1'b0, 10, q, r, lat, bc);
        check("ignore_quotient", q, 32'd100);
        check("ignore_remainder", r, 32'd0);
        check("ignore_latency", lat, 32'd33);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("ignore_no_second_op", {31'd0, busy}, 32'd0);

        // asynchronous reset mid-operation
        start = 1'b1; input1 = 32'd77; input2 = 32'd5; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_quotient", quotient, 32'd0);
        check("midreset_remainder", remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'd1000, 32'd10, 1'b0, -1, q, r, lat, bc);
        check("postreset_quotient", q, 32'd100);
        check("postreset_remainder", r, 32'd0);
        check("postreset_latency", lat, 32'd33);

        // randomized operands against the arithmetic reference
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            s = 1'($urandom_range(0, 1));
            exp = ref_div(a, b, s);
            run_op(a, b, s, -1, q, r, lat, bc);
            check($sformatf("rand%0d_quotient", k), q, exp[63:32]);
            check($sformatf("rand%0d_remainder", k), r, exp[31:0]);
            check($sformatf("rand%0d_latency", k), lat, 32'd33);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
